// File: rtl/fir_decim_scheduler.sv
// Decimating FIR scheduler: one shared MAC is stepped over all TAPS taps once every DECIM accepted samples.
// Optional FIR_SAT_EN clamps the dequantized result to DATA_WIDTH instead of wrapping it.
module fir_decim_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int TAPS        = 32,
    parameter int DECIM       = 8,
    parameter int BITS        = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEFF_WIDTH-1:0]   coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic [1:0]               state_dbg
);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W = PW + AW;
    localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCW-1:0] DCNT_LAST = DCW'(DECIM - 1);
    localparam logic [AW-1:0]  K_LAST    = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_WIDTH-1:0] hist [TAPS];
    logic [DCW-1:0]          dcnt;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic [PW-1:0]           op_a, op_b, prod;
    logic                    accept;
    logic                    round_up;
    logic [DATA_WIDTH-1:0]   result;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    // Operands are sign-extended to the full product width so an unsigned multiply yields the exact signed product.
    always_comb begin
        op_a    = {{COEFF_WIDTH{hist[k][DATA_WIDTH-1]}}, hist[k]};
        op_b    = {{DATA_WIDTH{coef_data[COEFF_WIDTH-1]}}, coef_data};
        prod    = op_a * op_b;
        acc_sum = acc + {{AW{prod[PW-1]}}, prod};
    end

    // Truncation toward zero: a negative sum with any fraction bits set rounds its floor up by one.
    if (BITS > 0) begin : g_frac
        assign round_up = acc_sum[ACC_W-1] && (acc_sum[BITS-1:0] != '0);
    end else begin : g_nofrac
        assign round_up = 1'b0;
    end

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    logic signed [ACC_W-1:0] deq_sh, deq;
    always_comb begin
        deq_sh = acc_sum >>> BITS;
        deq    = deq_sh + $signed({{(ACC_W-1){1'b0}}, round_up});
        if (deq > SAT_MAX)      result = SAT_MAX[DATA_WIDTH-1:0];
        else if (deq < SAT_MIN) result = SAT_MIN[DATA_WIDTH-1:0];
        else                    result = deq[DATA_WIDTH-1:0];
    end
`else
    assign result = acc_sum[BITS +: DATA_WIDTH] + {{(DATA_WIDTH-1){1'b0}}, round_up};
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        coef_addr = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && dcnt == DCNT_LAST) state_nxt = MAC;
            end
            MAC: begin
                busy      = 1'b1;
                coef_addr = k;
                if (k == K_LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dcnt     <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = TAPS - 1; i > 0; i--) hist[i] <= hist[i-1];
                        hist[0] <= in_data;
                        if (dcnt == DCNT_LAST) begin
                            dcnt <= '0;
                            acc  <= '0;
                            k    <= '0;
                        end else begin
                            dcnt <= dcnt + DCW'(1);
                        end
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    k   <= k + AW'(1);
                    // The final tap's sum is dequantized directly so out_data is ready on DONE entry.
                    if (k == K_LAST) out_data <= result;
                end
                default: ;
            endcase
        end
    end
endmodule
